// File: rtl/z80_bus_trace.sv
// z80_bus_trace: classifies tv80s bus cycles and queues time-stamped records in a first-word-fall-through FIFO.
// Optional macro BUS_TRACE_RFSH_EN records refresh cycles as type 7; undefined, refresh strobes count as idle.
module z80_bus_trace #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m1_n,
    input  logic          mreq_n,
    input  logic          iorq_n,
    input  logic          rd_n,
    input  logic          wr_n,
    input  logic          rfsh_n,
    input  logic [15:0]   A,
    input  logic [7:0]    di,
    input  logic [7:0]    dout,
    output logic          rec_valid,
    input  logic          rec_ready,
    output logic [2:0]    rec_type,
    output logic [15:0]   rec_addr,
    output logic [7:0]    rec_data,
    output logic [15:0]   rec_stamp,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    drop_cnt
);
    localparam int          RW     = 43;
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C  = (AW+1)'(1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    state_t          state_r, state_next_s;
    logic            cls_valid_s;
    logic [2:0]      cls_type_s;
    logic [7:0]      cls_data_s;
    logic            push_s, start_s, pop_s, push_ok_s;
    logic [2:0]      cur_type_r;
    logic [15:0]     cur_addr_r;
    logic [7:0]      cur_data_r;
    logic [15:0]     cur_stamp_r;
    logic [15:0]     tick_r;
    logic [RW-1:0]   rec_s;
    logic [RW-1:0]   mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r, rd_ptr_next_s;
    logic [AW:0]     count_r, count_next_s;
    logic            valid_r, overflow_r;
    logic [7:0]      drop_cnt_r;
    logic [RW-1:0]   head_r, head_next_s;

    // Decode the sampled strobes into a cycle type; fetch and int-ack take priority over plain accesses
    always_comb begin
        cls_valid_s = 1'b1;
        cls_type_s  = 3'd0;
        if (!m1_n && !mreq_n && !rd_n) begin
            cls_type_s = 3'd1;
        end else if (!m1_n && !iorq_n) begin
            cls_type_s = 3'd5;
        end else if (m1_n && !mreq_n && !rd_n) begin
            cls_type_s = 3'd0;
        end else if (!mreq_n && !wr_n) begin
            cls_type_s = 3'd2;
        end else if (m1_n && !iorq_n && !rd_n) begin
            cls_type_s = 3'd3;
        end else if (!iorq_n && !wr_n) begin
            cls_type_s = 3'd4;
`ifdef BUS_TRACE_RFSH_EN
        end else if (!mreq_n && !rfsh_n && rd_n && wr_n) begin
            cls_type_s = 3'd7;
`else
        end else if (!mreq_n && !rfsh_n && rd_n && wr_n) begin
            cls_valid_s = 1'b0;
`endif
        end else begin
            cls_valid_s = 1'b0;
        end
    end

    // Pick the data bus that carries the byte for this cycle type
    always_comb begin
        case (cls_type_s)
            3'd2, 3'd4: cls_data_s = dout;
            3'd7:       cls_data_s = 8'h00;
            default:    cls_data_s = di;
        endcase
    end

    // Cycle tracker state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // A type change closes the current record and opens the next one in the same edge
    always_comb begin
        state_next_s = state_r;
        push_s       = 1'b0;
        start_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cls_valid_s) begin
                    state_next_s = ST_ACTIVE;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (!cls_valid_s) begin
                    state_next_s = ST_IDLE;
                    push_s       = 1'b1;
                end else if (cls_type_s != cur_type_r) begin
                    state_next_s = ST_ACTIVE;
                    push_s       = 1'b1;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = ST_ACTIVE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Capture the record in progress; address and data follow the last active clock
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_type_r  <= 3'd0;
            cur_addr_r  <= 16'h0000;
            cur_data_r  <= 8'h00;
            cur_stamp_r <= 16'h0000;
        end else if (start_s) begin
            cur_type_r  <= cls_type_s;
            cur_addr_r  <= A;
            cur_data_r  <= cls_data_s;
            cur_stamp_r <= tick_r;
        end else if ((state_r == ST_ACTIVE) && cls_valid_s) begin
            cur_addr_r  <= A;
            cur_data_r  <= cls_data_s;
        end
    end

    // Free-running timestamp
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_r <= 16'h0000;
        end else begin
            tick_r <= tick_r + 16'd1;
        end
    end

    assign rec_s     = {cur_type_r, cur_addr_r, cur_data_r, cur_stamp_r};
    assign pop_s     = valid_r && rec_ready;
    assign push_ok_s = push_s && ((count_r != FULL_C) || pop_s);

    // Next occupancy and next head; the new record becomes head when nothing older remains
    always_comb begin
        if (push_ok_s && !pop_s) begin
            count_next_s = count_r + ONE_C;
        end else if (!push_ok_s && pop_s) begin
            count_next_s = count_r - ONE_C;
        end else begin
            count_next_s = count_r;
        end
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + 1'b1;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        if (count_next_s == '0) begin
            head_next_s = head_r;
        end else if ((count_r == '0) || (pop_s && (count_r == ONE_C))) begin
            head_next_s = rec_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= rec_s;
        end
    end

    // FIFO pointers, registered head and drop accounting
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            valid_r    <= 1'b0;
            head_r     <= '0;
            overflow_r <= 1'b0;
            drop_cnt_r <= 8'h00;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
            valid_r  <= (count_next_s != '0);
            head_r   <= head_next_s;
            if (push_s && !push_ok_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != 8'hFF) begin
                    drop_cnt_r <= drop_cnt_r + 8'd1;
                end
            end
        end
    end

    assign rec_valid = valid_r;
    assign rec_type  = head_r[42:40];
    assign rec_addr  = head_r[39:24];
    assign rec_data  = head_r[23:16];
    assign rec_stamp = head_r[15:0];
    assign count     = count_r;
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_z80_bus_trace.sv
// Bench for z80_bus_trace: drives whole bus cycles and checks drained records against a queue-based model.
module tb_z80_bus_trace;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef BUS_TRACE_RFSH_EN
    localparam bit RFSH = 1'b1;
`else
    localparam bit RFSH = 1'b0;
`endif

    logic clk, reset, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, rec_ready;
    logic [15:0] A;
    logic [7:0]  di, dout;
    logic        rec_valid, overflow;
    logic [2:0]  rec_type;
    logic [15:0] rec_addr, rec_stamp;
    logic [7:0]  rec_data, drop_cnt;
    logic [AW:0] count;

    z80_bus_trace #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .A(A), .di(di), .dout(dout),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_type(rec_type),
        .rec_addr(rec_addr), .rec_data(rec_data), .rec_stamp(rec_stamp),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  t;
        logic [15:0] a;
        logic [7:0]  d;
        logic [15:0] s;
    } rec_t;

    typedef struct {
        logic [5:0] strb;
        int         exp_cls;
        logic [7:0] exp_d;
    } cls_vec_t;

    int    n_chk = 0;
    int    n_err = 0;
    rec_t  exp_q[$];
    rec_t  got_q[$];
    rec_t  prog_exp[$];
    rec_t  pend;
    bit    pend_v;
    logic [15:0] m_tick;
    int    m_drop;
    bit    m_ovf;
    bit    rand_ready;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [5:0] strb_of(input int cls);
        case (cls)
            0:       return 6'b101011;
            1:       return 6'b001011;
            2:       return 6'b101101;
            3:       return 6'b110011;
            4:       return 6'b110101;
            5:       return 6'b010111;
            7:       return 6'b101110;
            default: return 6'b111111;
        endcase
    endfunction

    function automatic int eff_cls(input int cls);
        if (cls == 7) return RFSH ? 7 : -1;
        if (cls < 0 || cls > 7 || cls == 6) return -1;
        return cls;
    endfunction

    task automatic model_push(input rec_t r);
        if (exp_q.size() >= DEPTH) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
        end else begin
            exp_q.push_back(r);
        end
    endtask

    // One clock: consumer pop before the edge, producer bookkeeping after it, then status checks
    task automatic step(input bit seg_start, input int cls, input logic [15:0] a, input logic [7:0] d);
        rec_t g;
        if (rand_ready) rec_ready = 1'($urandom_range(0, 1));
        if (rec_ready && exp_q.size() > 0) begin
            g = '{rec_type, rec_addr, rec_data, rec_stamp};
            got_q.push_back(g);
            chk("head_type",  32'(rec_type),  32'(exp_q[0].t));
            chk("head_addr",  32'(rec_addr),  32'(exp_q[0].a));
            chk("head_data",  32'(rec_data),  32'(exp_q[0].d));
            chk("head_stamp", 32'(rec_stamp), 32'(exp_q[0].s));
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        if (seg_start) begin
            if (pend_v) model_push(pend);
            pend_v = (cls >= 0);
            pend.t = 3'(cls);
            pend.a = a;
            pend.d = d;
            pend.s = m_tick;
        end
        m_tick = m_tick + 16'd1;
        chk("count",     32'(count),     32'(exp_q.size()));
        chk("rec_valid", 32'(rec_valid), 32'(exp_q.size() != 0));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
    endtask

    // Hold a strobe pattern for len clocks; address/data are wrong except on the last clock
    task automatic seg_raw(input logic [5:0] strb, input int exp_cls, input logic [15:0] a,
                           input logic [7:0] v_di, input logic [7:0] v_do, input logic [7:0] exp_d,
                           input int len);
        for (int k = 0; k < len; k++) begin
            {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = strb;
            A    = (k == len - 1) ? a : ~a;
            di   = (k == len - 1) ? v_di : ~v_di;
            dout = (k == len - 1) ? v_do : ~v_do;
            step(k == 0, exp_cls, a, exp_d);
        end
    endtask

    task automatic seg(input int cls, input logic [15:0] a, input logic [7:0] d, input int len);
        seg_raw(strb_of(cls), eff_cls(cls), a, d, d, (cls == 7) ? 8'h00 : d, len);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = 6'b111111;
        exp_q.delete();
        pend_v = 1'b0;
        m_tick = 16'h0000;
        m_drop = 0;
        m_ovf  = 1'b0;
        chk("rst_valid", 32'(rec_valid), 32'd0);
        chk("rst_count", 32'(count),     32'd0);
        chk("rst_ovf",   32'(overflow),  32'd0);
        chk("rst_drop",  32'(drop_cnt),  32'd0);
        chk("rst_type",  32'(rec_type),  32'd0);
        chk("rst_addr",  32'(rec_addr),  32'd0);
        chk("rst_data",  32'(rec_data),  32'd0);
        chk("rst_stamp", 32'(rec_stamp), 32'd0);
    endtask

    cls_vec_t tab[12];

    initial begin
        tab[0]  = '{6'b001011, 1, 8'h3C};
        tab[1]  = '{6'b010111, 5, 8'h3C};
        tab[2]  = '{6'b101011, 0, 8'h3C};
        tab[3]  = '{6'b101101, 2, 8'hC3};
        tab[4]  = '{6'b110011, 3, 8'h3C};
        tab[5]  = '{6'b110101, 4, 8'hC3};
        tab[6]  = '{6'b101110, RFSH ? 7 : -1, 8'h00};
        tab[7]  = '{6'b111111, -1, 8'h00};
        tab[8]  = '{6'b111011, -1, 8'h00};
        tab[9]  = '{6'b101111, -1, 8'h00};
        tab[10] = '{6'b110111, -1, 8'h00};
        tab[11] = '{6'b011111, -1, 8'h00};

        rand_ready = 1'b0;
        rec_ready  = 1'b1;
        reset      = 1'b1;
        {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = 6'b111111;
        A = 16'h0000; di = 8'h00; dout = 8'h00;
        do_reset();

        // classification table
        for (int i = 0; i < 12; i++) begin
            seg_raw(tab[i].strb, tab[i].exp_cls, 16'h1000 + 16'(i), 8'h3C, 8'hC3, tab[i].exp_d, 2);
            seg(-1, 16'h0000, 8'h00, 1);
        end
        seg(-1, 16'h0000, 8'h00, 3);

        // FD CB C8 01 with [5BFD]=CB
        got_q.delete();
        seg(1, 16'h0000, 8'hFD, 2);
        seg(7, 16'h0010, 8'h00, 2);
        seg(1, 16'h0001, 8'hCB, 2);
        seg(7, 16'h0011, 8'h00, 2);
        seg(0, 16'h0002, 8'hC8, 3);
        seg(-1, 16'h0000, 8'h00, 1);
        seg(0, 16'h0003, 8'h01, 3);
        seg(-1, 16'h0000, 8'h00, 2);
        seg(0, 16'h5BFD, 8'hCB, 3);
        seg(-1, 16'h0000, 8'h00, 1);
        seg(2, 16'h5BFD, 8'h97, 3);
        seg(-1, 16'h0000, 8'h00, 4);
        prog_exp.push_back('{3'd1, 16'h0000, 8'hFD, 16'h0});
        if (RFSH) prog_exp.push_back('{3'd7, 16'h0010, 8'h00, 16'h0});
        prog_exp.push_back('{3'd1, 16'h0001, 8'hCB, 16'h0});
        if (RFSH) prog_exp.push_back('{3'd7, 16'h0011, 8'h00, 16'h0});
        prog_exp.push_back('{3'd0, 16'h0002, 8'hC8, 16'h0});
        prog_exp.push_back('{3'd0, 16'h0003, 8'h01, 16'h0});
        prog_exp.push_back('{3'd0, 16'h5BFD, 8'hCB, 16'h0});
        prog_exp.push_back('{3'd2, 16'h5BFD, 8'h97, 16'h0});
        chk("prog_len", 32'(got_q.size()), 32'(prog_exp.size()));
        for (int i = 0; i < prog_exp.size() && i < got_q.size(); i++) begin
            chk("prog_type", 32'(got_q[i].t), 32'(prog_exp[i].t));
            chk("prog_addr", 32'(got_q[i].a), 32'(prog_exp[i].a));
            chk("prog_data", 32'(got_q[i].d), 32'(prog_exp[i].d));
            if (i > 0) chk("prog_stamp_incr", 32'(got_q[i].s > got_q[i-1].s), 32'd1);
        end

        // overflow: DEPTH+3 records with no consumer
        rec_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            seg(0, 16'h3000 + 16'(i), 8'(i), 1);
            seg(-1, 16'h0000, 8'h00, 1);
        end
        chk("ovf_count", 32'(count),    32'd16);
        chk("ovf_flag",  32'(overflow), 32'd1);
        chk("ovf_drop",  32'(drop_cnt), 32'd3);
        got_q.delete();
        rec_ready = 1'b1;
        seg(-1, 16'h0000, 8'h00, DEPTH + 1);
        chk("ovf_popped", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < got_q.size(); i++) chk("ovf_order", 32'(got_q[i].a), 32'(16'h3000 + 16'(i)));
        chk("ovf_empty", 32'(count), 32'd0);

        // full FIFO with push and pop on the same edge
        rec_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            seg(0, 16'h4000 + 16'(i), 8'h40, 1);
            seg(-1, 16'h0000, 8'h00, 1);
        end
        seg(2, 16'h4100, 8'h41, 1);
        got_q.delete();
        rec_ready = 1'b1;
        seg(-1, 16'h0000, 8'h00, 1);
        rec_ready = 1'b0;
        chk("pp_count", 32'(count),    32'd16);
        chk("pp_drop",  32'(drop_cnt), 32'd3);
        chk("pp_ovf",   32'(overflow), 32'd1);
        rec_ready = 1'b1;
        seg(-1, 16'h0000, 8'h00, DEPTH + 2);
        chk("pp_popped", 32'(got_q.size()), 32'd17);
        if (got_q.size() == 17) begin
            chk("pp_tail_addr", 32'(got_q[16].a), 32'h4100);
            chk("pp_tail_type", 32'(got_q[16].t), 32'd2);
        end

        // randomized traffic with a random consumer
        begin
            int prev = -1;
            int c, e;
            rand_ready = 1'b1;
            for (int n = 0; n < 400; n++) begin
                c = int'($urandom_range(0, 7));
                e = eff_cls(c);
                if (e >= 0 && e == prev) seg(-1, 16'h0000, 8'h00, 1);
                seg(c, 16'($urandom), 8'($urandom), int'($urandom_range(1, 3)));
                prev = e;
            end
            rand_ready = 1'b0;
            rec_ready  = 1'b1;
            seg(-1, 16'h0000, 8'h00, DEPTH + 2);
        end

        // reset in the middle of a memory write
        rec_ready = 1'b0;
        seg(3, 16'h7777, 8'h77, 1);
        seg(-1, 16'h0000, 8'h00, 1);
        seg(2, 16'h5A5A, 8'hA5, 2);
        do_reset();
        got_q.delete();
        rec_ready = 1'b1;
        seg(0, 16'h2345, 8'h66, 2);
        seg(-1, 16'h0000, 8'h00, 3);
        chk("mr_len", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) begin
            chk("mr_addr",  32'(got_q[0].a), 32'h2345);
            chk("mr_stamp", 32'(got_q[0].s), 32'h0000);
        end

        // timestamp wrap FFFE -> 0000
        do_reset();
        rec_ready = 1'b0;
        while (m_tick != 16'hFFFE) step(1'b0, -1, 16'h0000, 8'h00);
        seg(0, 16'h1111, 8'h11, 1);
        seg(-1, 16'h0000, 8'h00, 1);
        seg(2, 16'h2222, 8'h22, 1);
        seg(-1, 16'h0000, 8'h00, 1);
        chk("wrap_count", 32'(count), 32'd2);
        got_q.delete();
        rec_ready = 1'b1;
        seg(-1, 16'h0000, 8'h00, 3);
        chk("wrap_len", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            chk("wrap_stamp0", 32'(got_q[0].s), 32'hFFFE);
            chk("wrap_stamp1", 32'(got_q[1].s), 32'h0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
